// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the two-wire serial word link (strobe + data).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_word_tx_pkg;

  // Transmitter FSM encoding, also used by the receiver-side models.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  // Default link timing: bits per word, CLK cycles per strobe half-period,
  // and strobe-low cycles after the last bit.
  localparam int DEF_WORD_LENGTH = 20;
  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_IDLE_GAP    = 8;

  // The phase timer must hold the larger of the two loaded durations.
  function automatic int timer_width(input int clk_div, input int idle_gap);
    int m;
    m = (clk_div > idle_gap) ? clk_div : idle_gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_phase_timer.sv
// Loadable down-counter with a terminal-count flag for strobe phases and the gap.
// Latency: o_tc is high once the count reaches zero; a load takes effect next cycle.
// Backpressure: none; the counter holds at zero until reloaded.
module serial_word_tx_phase_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load wins over counting; the count saturates at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/serial_word_tx.sv
// Serialises one parallel word into WORD_LENGTH strobe pulses, bit 0 first.
// Latency: first strobe rise CLK_DIV+1 cycles after accept; DONE after 2*CLK_DIV*WORD_LENGTH+IDLE_GAP+1.
// Backpressure: w_READY is low from accept until the gap ends; w_VALID is ignored meanwhile.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int IDLE_GAP    = DEF_IDLE_GAP
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WORD_LENGTH-1:0] b_DATA_IN,
  input  logic                   w_VALID,
  output logic                   w_READY,
  output logic                   w_SER_CLK,
  output logic                   w_SER_DATA,
  output logic                   w_BUSY,
  output logic                   w_DONE
);

  localparam int BW = $clog2(WORD_LENGTH) + 1;
  localparam int TW = timer_width(CLK_DIV, IDLE_GAP);

  // The first low phase is one cycle longer because the accept cycle itself
  // counts against it; every other phase lasts exactly its nominal length.
  localparam logic [TW-1:0] LD_FIRST = TW'(CLK_DIV);
  localparam logic [TW-1:0] LD_HALF  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LD_GAP   = TW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_LENGTH - 1);

  tx_state_t              r_state;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [BW-1:0]          r_bit_cnt;
  logic                   r_ser_clk;
  logic                   r_ser_data;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_tc;
  logic                   w_last_bit;
  logic                   w_enter_idle;
  logic                   w_load;
  logic [TW-1:0]          w_load_val;
  logic [WORD_LENGTH-1:0] w_shift_next;

  assign w_accept     = (r_state == ST_IDLE) && r_ready && w_VALID;
  assign w_last_bit   = (r_bit_cnt == LAST_BIT);
  assign w_shift_next = r_shift >> 1;

  // Return to IDLE either at the end of the gap or, with no gap configured,
  // straight from the falling edge of the last strobe.
  assign w_enter_idle = ((r_state == ST_GAP) && w_tc) ||
                        ((r_state == ST_HIGH) && w_tc && w_last_bit && (IDLE_GAP == 0));

  // Choose when and with what duration to restart the phase timer.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_load_val = LD_FIRST;
        end
      end
      ST_LOW: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = LD_HALF;
        end
      end
      ST_HIGH: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = w_last_bit ? LD_GAP : LD_HALF;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  serial_word_tx_phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Transmit FSM; every output is a register so nothing is combinational from inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_ser_clk  <= 1'b0;
      r_ser_data <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // Latch the whole word so the input may change freely while busy.
            r_shift    <= b_DATA_IN;
            r_ser_data <= b_DATA_IN[0];
            r_bit_cnt  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOW;
          end else begin
            // READY comes up on the first clock after reset release.
            r_ready    <= 1'b1;
            r_ser_data <= 1'b0;
          end
        end
        ST_LOW: begin
          if (w_tc) begin
            r_ser_clk <= 1'b1;
            r_state   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_tc) begin
            // Data only moves together with the falling strobe.
            r_ser_clk <= 1'b0;
            if (w_last_bit) begin
              if (IDLE_GAP != 0) begin
                r_state <= ST_GAP;
              end
            end else begin
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              r_shift    <= w_shift_next;
              r_ser_data <= w_shift_next[0];
              r_state    <= ST_LOW;
            end
          end
        end
        default: begin
          // ST_GAP: strobe stays low and the last bit is held; exit handled below.
          r_ser_clk <= 1'b0;
        end
      endcase

      if (w_enter_idle) begin
        r_state    <= ST_IDLE;
        r_ready    <= 1'b1;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_ser_data <= 1'b0;
      end
    end
  end

  assign w_READY    = r_ready;
  assign w_SER_CLK  = r_ser_clk;
  assign w_SER_DATA = r_ser_data;
  assign w_BUSY     = r_busy;
  assign w_DONE     = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx with a shift-in receiver model on the strobe.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_word_tx;

  localparam int WL = 20;
  localparam int CD = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [WL-1:0] a_data = '0;
  logic          a_vld  = 1'b0;
  logic          a_ready, a_sclk, a_sdata, a_busy, a_done;
  logic [WL-1:0] b_data = '0;
  logic          b_vld  = 1'b0;
  logic          b_ready, b_sclk, b_sdata, b_busy, b_done;

  serial_word_tx #(.WORD_LENGTH(WL), .CLK_DIV(CD), .IDLE_GAP(3)) dut_a (
    .CLK(CLK), .RST(RST), .b_DATA_IN(a_data), .w_VALID(a_vld), .w_READY(a_ready),
    .w_SER_CLK(a_sclk), .w_SER_DATA(a_sdata), .w_BUSY(a_busy), .w_DONE(a_done));

  serial_word_tx #(.WORD_LENGTH(WL), .CLK_DIV(CD), .IDLE_GAP(0)) dut_b (
    .CLK(CLK), .RST(RST), .b_DATA_IN(b_data), .w_VALID(b_vld), .w_READY(b_ready),
    .w_SER_CLK(b_sclk), .w_SER_DATA(b_sdata), .w_BUSY(b_busy), .w_DONE(b_done));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Receiver model and observers for DUT A (IDLE_GAP=3)
  int            a_pulses = 0, a_rxcnt = 0, a_done_cnt = 0, a_acc_on_done = 0;
  int            a_stab_err = 0, a_acc_edge = 0;
  logic [WL-1:0] a_rxbuf = '0;
  logic [WL-1:0] a_rx_q[$];
  int            a_lat_q[$];
  logic          a_prev_clk = 0, a_prev_data = 0, a_prev_busy = 0, a_prev_acc = 0;

  always @(negedge CLK) begin
    if (RST) begin
      a_rxcnt = 0; a_prev_clk = 0; a_prev_data = 0; a_prev_busy = 0; a_prev_acc = 0;
    end else begin
      if (a_sclk && !a_prev_clk) begin
        a_pulses++;
        a_rxbuf[a_rxcnt] = a_sdata;
        a_rxcnt++;
        if (a_rxcnt == WL) begin
          a_rx_q.push_back(a_rxbuf);
          a_rxcnt = 0;
        end
      end
      if (a_prev_clk && a_sclk && (a_sdata !== a_prev_data)) a_stab_err++;
      if ((a_sdata !== a_prev_data) && !(a_prev_clk && !a_sclk) && !a_prev_acc &&
          !(a_prev_busy && !a_busy)) a_stab_err++;
      if (a_done) begin
        a_done_cnt++;
        a_lat_q.push_back(cyc - a_acc_edge);
        if (a_vld && a_ready) a_acc_on_done++;
      end
      if (a_vld && a_ready) a_acc_edge = cyc + 1;
      a_prev_clk  = a_sclk;
      a_prev_data = a_sdata;
      a_prev_busy = a_busy;
      a_prev_acc  = a_vld && a_ready;
    end
  end

  // Receiver model and observers for DUT B (IDLE_GAP=0)
  int            b_pulses = 0, b_rxcnt = 0, b_acc_edge = 0, b_done_at_fall = 0;
  logic [WL-1:0] b_rxbuf = '0;
  logic [WL-1:0] b_rx_q[$];
  int            b_lat_q[$];
  logic          b_prev_clk = 0;

  always @(negedge CLK) begin
    if (RST) begin
      b_rxcnt = 0; b_prev_clk = 0;
    end else begin
      if (b_sclk && !b_prev_clk) begin
        b_pulses++;
        b_rxbuf[b_rxcnt] = b_sdata;
        b_rxcnt++;
        if (b_rxcnt == WL) begin
          b_rx_q.push_back(b_rxbuf);
          b_rxcnt = 0;
        end
      end
      if (b_done) begin
        b_lat_q.push_back(cyc - b_acc_edge);
        if (b_prev_clk && !b_sclk && b_ready) b_done_at_fall++;
      end
      if (b_vld && b_ready) b_acc_edge = cyc + 1;
      b_prev_clk = b_sclk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [31:0] pop_a_rx();
    if (a_rx_q.size() == 0) return 'x;
    return 32'(a_rx_q.pop_front());
  endfunction

  function automatic logic [31:0] pop_a_lat();
    if (a_lat_q.size() == 0) return 'x;
    return 32'(a_lat_q.pop_front());
  endfunction

  // Present a word and hold VALID until the accept edge has passed.
  task automatic accept_a(input logic [WL-1:0] w);
    int n = 0;
    a_data = w;
    a_vld  = 1'b1;
    @(posedge CLK); #1;
    while (a_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) timeout_fail("accept_a");
  endtask

  // Wait for the done cycle, then one more cycle so the observers have seen it.
  task automatic wait_idle_a();
    int n = 0;
    while (!(a_ready && !a_busy) && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 400) timeout_fail("wait_idle_a");
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [WL-1:0] word;
    int            exp_pulses;
    int            exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int n;

    // 20 pulses of 2*CD cycles each, plus IDLE_GAP=3, plus the accept cycle
    vecs[0] = '{20'hA5A5A, 20, 84};
    vecs[1] = '{20'h00000, 20, 84};
    vecs[2] = '{20'hFFFFF, 20, 84};
    vecs[3] = '{20'h80001, 20, 84};
    vecs[4] = '{20'h12345, 20, 84};

    // Reset state
    #12;
    check("rst_ready", a_ready, 0);
    check("rst_sclk",  a_sclk,  0);
    check("rst_sdata", a_sdata, 0);
    check("rst_busy",  a_busy,  0);
    check("rst_done",  a_done,  0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_release", a_ready, 1);
    check("busy_after_release",  a_busy,  0);

    // Table-driven single words
    for (int i = 0; i < 5; i++) begin
      base  = a_pulses;
      dbase = a_done_cnt;
      accept_a(vecs[i].word);
      a_vld = 1'b0;
      wait_idle_a();
      check($sformatf("vec%0d_pulses", i), a_pulses - base, vecs[i].exp_pulses);
      check($sformatf("vec%0d_word", i), pop_a_rx(), 32'(vecs[i].word));
      check($sformatf("vec%0d_done_lat", i), pop_a_lat(), vecs[i].exp_lat);
      check($sformatf("vec%0d_done_once", i), a_done_cnt - dbase, 1);
      check($sformatf("vec%0d_idle_data", i), a_sdata, 0);
    end

    // Back-to-back with VALID held
    base = a_pulses;
    accept_a(20'hFFFFF);
    a_data = 20'h00001;
    n = 0;
    while (!a_ready && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 400) timeout_fail("b2b_wait_done");
    check("b2b_done_with_ready", a_done, 1);
    @(posedge CLK); #1;
    check("b2b_second_accepted", a_ready, 0);
    a_vld = 1'b0;
    wait_idle_a();
    check("b2b_pulses", a_pulses - base, 40);
    check("b2b_word0", pop_a_rx(), 32'h0FFFFF);
    check("b2b_word1", pop_a_rx(), 32'h000001);
    check("b2b_accept_on_done", a_acc_on_done, 1);
    check("b2b_lat0", pop_a_lat(), 84);
    check("b2b_lat1", pop_a_lat(), 84);

    // Input churn while busy
    base = a_pulses;
    accept_a(20'h3C3C3);
    n = 0;
    while (a_busy && n < 400) begin
      a_data = WL'($urandom);
      a_vld  = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      n++;
    end
    a_vld = 1'b0;
    if (n >= 400) timeout_fail("churn_wait");
    @(posedge CLK); #1;
    check("churn_pulses", a_pulses - base, 20);
    check("churn_word", pop_a_rx(), 32'h3C3C3);
    void'(pop_a_lat());

    // Reset after the 7th rising strobe
    base = a_pulses;
    accept_a(20'h5A5A5);
    a_vld = 1'b0;
    n = 0;
    while ((a_pulses - base) < 7 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) timeout_fail("mid_word_wait");
    check("mid_strobe_high", a_sclk, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_sclk",  a_sclk,  0);
    check("mid_rst_sdata", a_sdata, 0);
    check("mid_rst_ready", a_ready, 0);
    check("mid_rst_busy",  a_busy,  0);
    @(posedge CLK); #1;
    check("mid_rst_ready_hold", a_ready, 0);
    check("mid_rst_sclk_hold",  a_sclk,  0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("mid_ready_after_release", a_ready, 1);
    check("mid_no_extra_pulse", a_pulses - base, 7);
    base = a_pulses;
    accept_a(20'h0F0F0);
    a_vld = 1'b0;
    wait_idle_a();
    check("post_rst_pulses", a_pulses - base, 20);
    check("post_rst_word", pop_a_rx(), 32'h0F0F0);
    check("post_rst_lat", pop_a_lat(), 84);

    // IDLE_GAP=0 variant
    base = b_pulses;
    b_data = 20'hC3A5F;
    b_vld  = 1'b1;
    n = 0;
    @(posedge CLK); #1;
    while (b_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) timeout_fail("accept_b");
    b_vld = 1'b0;
    n = 0;
    while (!(b_ready && !b_busy) && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 400) timeout_fail("wait_idle_b");
    @(posedge CLK); #1;
    check("gap0_pulses", b_pulses - base, 20);
    check("gap0_word", (b_rx_q.size() > 0) ? 32'(b_rx_q.pop_front()) : 'x, 32'hC3A5F);
    check("gap0_done_lat", (b_lat_q.size() > 0) ? 32'(b_lat_q.pop_front()) : 'x, 81);
    check("gap0_ready_at_fall", b_done_at_fall, 1);

    // Data only ever moved at a strobe fall, an accept or the return to idle
    check("data_stability", a_stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
